// File: rtl/pipe_stage_ctrl.sv
// rtl/pipe_stage_ctrl.sv - N-stage valid/allow_in pipeline controller with per-stage bus latches
// Define PIPE_PERF_EN to add saturating retire/stall/flush counters; otherwise the perf ports are 0.
module pipe_stage_ctrl #(
    parameter int STAGES = 5,
    parameter int BUS_W  = 64,
    parameter int PERF_W = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [BUS_W-1:0]            in_bus,
    output logic                        in_ready,
    input  logic [STAGES-1:0]           stage_over,
    input  logic [(STAGES-1)*BUS_W-1:0] stage_bus_next,
    output logic [STAGES-1:0]           stage_valid,
    output logic [STAGES-1:0]           stage_allow_in,
    output logic [STAGES*BUS_W-1:0]     stage_bus,
    output logic                        out_valid,
    input  logic                        out_ready,
    input  logic                        flush,
    input  logic [STAGES-1:0]           flush_mask,
    output logic [PERF_W-1:0]           perf_retire,
    output logic [PERF_W-1:0]           perf_stall,
    output logic [PERF_W-1:0]           perf_flush
);

    logic [STAGES-1:0]       r_valid;
    logic [STAGES*BUS_W-1:0] r_bus;
    logic [STAGES-1:0]       w_ov;
    logic [STAGES-1:0]       w_kill;
    logic [STAGES-1:0]       w_allow;
    logic [STAGES-1:0]       w_take;
    logic [STAGES-1:0]       w_load;
    logic [STAGES*BUS_W-1:0] w_src;

    // Slice 0 is the source entry, slice i is the datapath output of stage i-1.
    assign w_src = {stage_bus_next, in_bus};

    // Allow chain evaluated back-to-front through a local accumulator so the
    // vector never depends on its own bits.
    always_comb begin
        logic w_acc;
        w_ov    = r_valid & stage_over;
        w_kill  = flush ? flush_mask : '0;
        w_allow = '0;
        w_acc   = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_acc      = ~r_valid[i] | (w_ov[i] & w_acc);
            w_allow[i] = w_acc;
        end
    end

    always_comb begin
        w_take    = '0;
        w_load    = '0;
        w_take[0] = in_valid;
        w_load[0] = in_valid & w_allow[0] & ~w_kill[0];
        for (int i = 1; i < STAGES; i++) begin
            w_take[i] = w_ov[i-1] & ~w_kill[i-1];
            w_load[i] = w_ov[i-1] & ~w_kill[i-1] & w_allow[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_bus   <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (w_kill[i]) begin
                    r_valid[i] <= 1'b0;
                end else if (w_allow[i]) begin
                    r_valid[i] <= w_take[i];
                end
                if (w_load[i]) begin
                    r_bus[i*BUS_W +: BUS_W] <= w_src[i*BUS_W +: BUS_W];
                end
            end
        end
    end

    assign stage_valid    = r_valid;
    assign stage_allow_in = w_allow;
    assign stage_bus      = r_bus;
    assign in_ready       = w_allow[0] | w_kill[0];
    assign out_valid      = w_ov[STAGES-1] & ~w_kill[STAGES-1];

`ifdef PIPE_PERF_EN
    logic [PERF_W-1:0] r_retire;
    logic [PERF_W-1:0] r_stall;
    logic [PERF_W-1:0] r_flush;
    logic              w_retire;
    logic              w_stall;

    assign w_retire = out_valid & out_ready;
    assign w_stall  = in_valid & ~in_ready;

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retire <= '0;
            r_stall  <= '0;
            r_flush  <= '0;
        end else begin
            if (w_retire && (r_retire != '1)) r_retire <= r_retire + PERF_W'(1);
            if (w_stall && (r_stall != '1))   r_stall  <= r_stall + PERF_W'(1);
            if (flush && (r_flush != '1))     r_flush  <= r_flush + PERF_W'(1);
        end
    end

    assign perf_retire = r_retire;
    assign perf_stall  = r_stall;
    assign perf_flush  = r_flush;
`else
    assign perf_retire = '0;
    assign perf_stall  = '0;
    assign perf_flush  = '0;
`endif

endmodule
